// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with sign fix-up and RISC-V divide special cases.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [6:0]       Funct7,
    input  logic [2:0]       Funct3,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Result,
    output logic             Busy,
    output logic             Done
);
    localparam int                CNT_W     = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]  ZERO_W    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]  ONES_W    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]  MIN_W     = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [2:0]        F3_MUL    = 3'b000;
    localparam logic [2:0]        F3_MULH   = 3'b001;
    localparam logic [2:0]        F3_MULHSU = 3'b010;
    localparam logic [2:0]        F3_DIV    = 3'b100;
    localparam logic [2:0]        F3_REM    = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic               neg_q, neg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               accept_s, sign_a_s, sign_b_s, div_zero_s, ovf_s, special_s;
    logic [WIDTH-1:0]   mag_a_s, mag_b_s, special_res_s;
    logic [WIDTH:0]     mul_sum_s, div_shift_s, div_diff_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0]   quo_fix_s, rem_fix_s;

    assign accept_s   = (state_q == S_IDLE) && Start && (Funct7 == 7'b0000001);
    assign sign_a_s   = ((Funct3 == F3_MULH) || (Funct3 == F3_MULHSU) ||
                         (Funct3 == F3_DIV)  || (Funct3 == F3_REM)) && A[WIDTH-1];
    assign sign_b_s   = ((Funct3 == F3_MULH) || (Funct3 == F3_DIV) ||
                         (Funct3 == F3_REM)) && B[WIDTH-1];
    assign mag_a_s    = sign_a_s ? neg_w(A) : A;
    assign mag_b_s    = sign_b_s ? neg_w(B) : B;
    assign div_zero_s = Funct3[2] && (B == ZERO_W);
    assign ovf_s      = ((Funct3 == F3_DIV) || (Funct3 == F3_REM)) && (A == MIN_W) && (B == ONES_W);
    assign special_s  = div_zero_s || ovf_s;

    // The multiplier lives in the low half of acc_q and is consumed LSB first.
    assign mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                         (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    assign div_shift_s = {rem_q, quo_q[WIDTH-1]};
    assign div_diff_s  = div_shift_s - {1'b0, opnd_q};

    assign prod_fix_s = neg_q ? neg_2w(acc_q) : acc_q;
    assign quo_fix_s  = neg_q ? neg_w(quo_q) : quo_q;
    assign rem_fix_s  = neg_q ? neg_w(rem_q) : rem_q;

    // Result for accepts that bypass iteration.
    always_comb begin
        special_res_s = ZERO_W;
        if (div_zero_s) begin
            special_res_s = Funct3[1] ? A : ONES_W;
        end else if (ovf_s) begin
            special_res_s = Funct3[1] ? ZERO_W : A;
        end else begin
            special_res_s = ZERO_W;
        end
    end

    // FSM next state and registered status flags.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = special_s ? S_DONE : S_CALC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (cnt_q == LAST_ITER) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_CALC) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    // Datapath: operand capture, one iteration per CALC cycle, sign fix-up in FIX.
    always_comb begin
        op_d     = op_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    op_d   = Funct3;
                    neg_d  = (Funct3[2] && Funct3[1]) ? sign_a_s : (sign_a_s ^ sign_b_s);
                    cnt_d  = {CNT_W{1'b0}};
                    acc_d  = {ZERO_W, mag_a_s};
                    opnd_d = mag_b_s;
                    rem_d  = ZERO_W;
                    quo_d  = mag_a_s;
                    if (special_s) begin
                        result_d = special_res_s;
                    end else begin
                        result_d = result_q;
                    end
                end else begin
                    op_d = op_q;
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + CNT_ONE;
                if (op_q[2]) begin
                    if (div_diff_s[WIDTH]) begin
                        rem_d = div_shift_s[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end else begin
                        rem_d = div_diff_s[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end
                end else begin
                    acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
                end
            end
            S_FIX: begin
                case (op_q)
                    F3_MUL:                  result_d = prod_fix_s[WIDTH-1:0];
                    3'b001, 3'b010, 3'b011:  result_d = prod_fix_s[2*WIDTH-1:WIDTH];
                    3'b100, 3'b101:          result_d = quo_fix_s;
                    3'b110, 3'b111:          result_d = rem_fix_s;
                    default:                 result_d = result_q;
                endcase
            end
            default: begin
                result_d = result_q;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= 3'b000;
            neg_q    <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
            acc_q    <= {(2*WIDTH){1'b0}};
            opnd_q   <= ZERO_W;
            rem_q    <= ZERO_W;
            quo_q    <= ZERO_W;
            result_q <= ZERO_W;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign Result = result_q;
    assign Busy   = busy_q;
    assign Done   = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised and directed bench for muldiv_unit against a plain-arithmetic RV32M model.
module tb_muldiv_unit;
    localparam int W = 32;
    localparam logic [6:0] F7_M = 7'b0000001;

    logic          clk;
    logic          reset;
    logic          Start;
    logic [6:0]    Funct7;
    logic [2:0]    Funct3;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic [W-1:0]  Result;
    logic          Busy;
    logic          Done;

    int            n_vec;
    int            n_err;
    logic [W-1:0]  last_res;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .Start  (Start),
        .Funct7 (Funct7),
        .Funct3 (Funct3),
        .A      (A),
        .B      (B),
        .Result (Result),
        .Busy   (Busy),
        .Done   (Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // RV32M semantics from the ISA definition, using wide integer arithmetic.
    function automatic logic [W-1:0] ref_model(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b);
        longint    sa, sb, ua, ub;
        logic [63:0] p;
        int        ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        ia = a;
        ib = b;
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return ia / ib;
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return ia % ib;
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b);
        if (!f3[2]) return 1'b0;
        if (b == 32'd0) return 1'b1;
        return !f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Leaves the caller in cycle 1 with Start low and operand inputs scrambled.
    task automatic start_op(input logic [6:0] f7, input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b);
        Funct7 = f7; Funct3 = f3; A = a; B = b; Start = 1'b1;
        tick();
        Start = 1'b0; Funct3 = 3'($urandom); A = $urandom; B = $urandom;
    endtask

    task automatic wait_done(input int from_cyc, output int done_cyc, output logic [W-1:0] res);
        done_cyc = 0;
        res = '0;
        for (int c = from_cyc; c <= from_cyc + 60; c++) begin
            if (Done) begin
                done_cyc = c;
                res = Result;
                break;
            end
            tick();
        end
    endtask

    // Returns in the cycle after Done so the next op starts in the first IDLE cycle.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_r);
        bit           spec;
        int           busy_err, done_cyc, done_cnt;
        logic [W-1:0] res;
        bit           exp_busy;
        spec = is_special(f3, a, b);
        busy_err = 0; done_cyc = 0; done_cnt = 0; res = '0;
        start_op(F7_M, f3, a, b);
        for (int cyc = 1; cyc <= W + 10; cyc++) begin
            exp_busy = !spec && (cyc <= W + 1);
            if (Busy !== exp_busy) busy_err++;
            if (Done) begin
                done_cnt++;
                if (done_cyc == 0) begin
                    done_cyc = cyc;
                    res = Result;
                end
            end
            if (done_cyc != 0 && cyc > done_cyc) break;
            tick();
        end
        check_eq({tag, " result"}, res, exp_r);
        check_eq({tag, " done_cycle"}, done_cyc, spec ? 1 : W + 2);
        check_eq({tag, " done_pulses"}, done_cnt, 1);
        check_eq({tag, " busy_errors"}, busy_err, 0);
        last_res = exp_r;
    endtask

    initial begin
        int           dc, busy_seen, done_seen;
        logic [W-1:0] r, a, b;
        logic [2:0]   f3;
        n_vec = 0; n_err = 0; last_res = '0;
        reset = 1'b1; Start = 1'b0; Funct7 = 7'd0; Funct3 = 3'd0; A = '0; B = '0;
        repeat (3) tick();
        check_eq("reset_result", Result, 32'd0);
        check_eq("reset_busy", Busy, 1'b0);
        check_eq("reset_done", Done, 1'b0);
        reset = 1'b0;

        run_op("mul_neg", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        repeat (5) tick();
        check_eq("mul_hold_c40", Result, 32'hFFFF_FFEB);

        run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mulhsu_m1", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhsu_2", 3'd2, 32'h0000_0002, 32'h8000_0000, 32'h0000_0001);
        run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14);
        run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2);
        run_op("divu_by0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_op("rem_by0", 3'd6, 32'd5, 32'd0, 32'd5);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        // Start while busy must not disturb the running divide.
        start_op(F7_M, 3'd4, 32'hFFFF_FFF9, 32'd2);
        repeat (4) tick();
        Funct7 = F7_M; Funct3 = 3'd5; A = 32'd9; B = 32'd2; Start = 1'b1;
        tick();
        Start = 1'b0;
        wait_done(6, dc, r);
        check_eq("busy_start_done_cycle", dc, W + 2);
        check_eq("busy_start_result", r, 32'hFFFF_FFFD);

        // Start during DONE is ignored.
        Funct7 = F7_M; Funct3 = 3'd0; A = 32'd3; B = 32'd3; Start = 1'b1;
        tick();
        Start = 1'b0;
        busy_seen = 0;
        repeat (3) begin
            if (Busy || Done) busy_seen++;
            tick();
        end
        check_eq("start_in_done_ignored", busy_seen, 0);
        check_eq("start_in_done_result", Result, 32'hFFFF_FFFD);

        // Reset in the middle of a divide aborts it.
        start_op(F7_M, 3'd4, 32'd1000, 32'd3);
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("midreset_busy", Busy, 1'b0);
        check_eq("midreset_done", Done, 1'b0);
        check_eq("midreset_result", Result, 32'd0);
        last_res = '0;
        run_op("divu_9_2", 3'd5, 32'd9, 32'd2, 32'd4);

        // Reset wins over a simultaneous Start in IDLE.
        reset = 1'b1; Funct7 = F7_M; Funct3 = 3'd5; A = 32'd50; B = 32'd5; Start = 1'b1;
        tick();
        reset = 1'b0; Start = 1'b0;
        tick();
        check_eq("reset_vs_start_busy", Busy, 1'b0);
        check_eq("reset_vs_start_result", Result, 32'd0);
        last_res = '0;

        run_op("mul_seed", 3'd0, 32'd6, 32'd7, 32'd42);

        // Wrong Funct7 is never accepted.
        Funct7 = 7'b0000000; Funct3 = 3'd5; A = 32'd9; B = 32'd2; Start = 1'b1;
        tick();
        Funct7 = 7'b0100000; Funct3 = 3'd4; B = 32'd0;
        tick();
        Start = 1'b0;
        busy_seen = 0; done_seen = 0;
        repeat (5) begin
            if (Busy) busy_seen++;
            if (Done) done_seen++;
            tick();
        end
        check_eq("f7_bad_busy", busy_seen, 0);
        check_eq("f7_bad_done", done_seen, 0);
        check_eq("f7_bad_result", Result, last_res);

        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            run_op($sformatf("rnd%0d_f3_%0d", i, f3), f3, a, b, ref_model(f3, a, b));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
